// File: rtl/bp_pkg.sv
// Shared types for the execute-stage branch resolver: training-update entry
// and resolver FSM state encoding.
package bp_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
   } upd_t;

   typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH} state_t;

   // Wrong direction, or taken to the wrong place.
   function automatic logic lane_mispredict(input logic is_br, input logic taken,
                                            input logic pred, input logic [31:0] tgt,
                                            input logic [31:0] pred_tgt);
      return is_br && ((taken != pred) || (taken && (tgt != pred_tgt)));
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Predictor-training update FIFO: up to two writes per cycle (slot 0 first),
// one read per cycle, and free-slot count that already credits this cycle's read.
module bp_update_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic [1:0]       wr_en,
   input  upd_t [1:0]       wr_data,
   input  logic             rd_en,
   output logic             head_valid,
   output upd_t             head,
   output logic [CNT_W-1:0] free
);

   localparam int PW = $clog2(DEPTH);

   upd_t             mem [DEPTH];
   logic [PW-1:0]    wptr, rptr, wptr1;
   logic [CNT_W-1:0] count;
   logic             deq;

   assign head_valid = (count != '0);
   assign head       = mem[rptr];
   assign deq        = rd_en && head_valid;
   assign free       = CNT_W'(DEPTH) - count + CNT_W'(deq);
   // A lone slot-1 write lands at wptr, so slot 1 skips ahead only behind slot 0.
   assign wptr1      = wptr + PW'(wr_en[0]);

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en[0]) mem[wptr]  <= wr_data[0];
         if (wr_en[1]) mem[wptr1] <= wr_data[1];
         wptr  <= wptr + PW'(wr_en[0]) + PW'(wr_en[1]);
         rptr  <= rptr + PW'(deq);
         count <= count + CNT_W'(wr_en[0]) + CNT_W'(wr_en[1]) - CNT_W'(deq);
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Dual-lane execute-stage branch resolution: held redirect toward fetch,
// flush sequencing, and queued BTB/PHT training updates.
module branch_resolver
   import bp_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        pc_we_i,
   input  logic        l0_valid_i,
   input  logic        l1_valid_i,
   input  logic [31:0] l0_pc_i,
   input  logic [31:0] l1_pc_i,
   input  logic        l0_is_br_i,
   input  logic        l1_is_br_i,
   input  logic        l0_taken_i,
   input  logic        l1_taken_i,
   input  logic [31:0] l0_tgt_i,
   input  logic [31:0] l1_tgt_i,
   input  logic        l0_pred_i,
   input  logic        l1_pred_i,
   input  logic [31:0] l0_pred_tgt_i,
   input  logic [31:0] l1_pred_tgt_i,
   output logic        wrong_pred_o,
   output logic [31:0] fixed_pc_o,
   output logic        wasnt_branch_o,
   output logic [31:0] wasnt_br_pc_o,
   output logic        update_pht_o,
   output logic        update_btb_o,
   output logic [31:0] update_pc_o,
   output logic [31:0] update_tgt_o,
   output logic        last_br_o,
   output logic        flush_o,
   output logic        drop_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int CW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wp_d, wb_d, drop_d;
   logic [31:0]      fix_d, wbpc_d;
   logic             mis0, ft0, mis1, ft1, in_run, req0, req1;
   logic [31:0]      fix0, fix1;
   logic [1:0]       wr_en;
   upd_t [1:0]       wr_data;
   logic             head_valid;
   upd_t             head;
   logic [CNT_W-1:0] free;

   assign mis0 = l0_valid_i && lane_mispredict(l0_is_br_i, l0_taken_i, l0_pred_i, l0_tgt_i, l0_pred_tgt_i);
   assign mis1 = l1_valid_i && lane_mispredict(l1_is_br_i, l1_taken_i, l1_pred_i, l1_tgt_i, l1_pred_tgt_i);
   assign ft0  = l0_valid_i && !l0_is_br_i && l0_pred_i;
   assign ft1  = l1_valid_i && !l1_is_br_i && l1_pred_i;
   assign fix0 = l0_taken_i ? l0_tgt_i : l0_pc_i + 32'd4;
   assign fix1 = l1_taken_i ? l1_tgt_i : l1_pc_i + 32'd4;

   // A lane-0 redirect squashes lane 1 entirely, including its training update.
   assign in_run = (state_q == S_RUN);
   assign req0   = in_run && l0_valid_i && l0_is_br_i;
   assign req1   = in_run && l1_valid_i && l1_is_br_i && !(mis0 || ft0);

   assign wr_data[0] = '{pc: l0_pc_i, tgt: l0_tgt_i, taken: l0_taken_i};
   assign wr_data[1] = '{pc: l1_pc_i, tgt: l1_tgt_i, taken: l1_taken_i};

   always_comb begin
      wr_en  = 2'b00;
      drop_d = 1'b0;
      if (req0 && req1) begin
         if (free >= CNT_W'(2))   wr_en = 2'b11;
         else if (free != '0)     wr_en = 2'b01;
         drop_d = (free < CNT_W'(2));
      end else if (req0) begin
         wr_en[0] = (free != '0);
         drop_d   = (free == '0);
      end else if (req1) begin
         wr_en[1] = (free != '0);
         drop_d   = (free == '0);
      end
   end

   bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_en      (pc_we_i),
      .head_valid (head_valid),
      .head       (head),
      .free       (free)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wp_d    = wrong_pred_o;
      fix_d   = fixed_pc_o;
      wb_d    = wasnt_branch_o;
      wbpc_d  = wasnt_br_pc_o;
      case (state_q)
         S_RUN: begin
            if (mis0) begin
               wp_d = 1'b1; fix_d = fix0; state_d = S_HOLD;
            end else if (ft0) begin
               wb_d = 1'b1; wbpc_d = l0_pc_i; state_d = S_HOLD;
            end else if (mis1) begin
               wp_d = 1'b1; fix_d = fix1; state_d = S_HOLD;
            end else if (ft1) begin
               wb_d = 1'b1; wbpc_d = l1_pc_i; state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (pc_we_i) begin
               wp_d   = 1'b0;
               fix_d  = '0;
               wb_d   = 1'b0;
               wbpc_d = '0;
               if (FLUSH_CYCLES == 0) begin
                  state_d = S_RUN;
               end else begin
                  cnt_d   = CW'(FLUSH_CYCLES);
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q        <= S_RUN;
         cnt_q          <= '0;
         wrong_pred_o   <= 1'b0;
         fixed_pc_o     <= '0;
         wasnt_branch_o <= 1'b0;
         wasnt_br_pc_o  <= '0;
         drop_o         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wrong_pred_o   <= wp_d;
         fixed_pc_o     <= fix_d;
         wasnt_branch_o <= wb_d;
         wasnt_br_pc_o  <= wbpc_d;
         drop_o         <= drop_d;
      end
   end

   assign flush_o      = (state_q != S_RUN);
   assign update_pht_o = head_valid;
   assign update_btb_o = head_valid && head.taken;
   assign last_br_o    = head_valid && head.taken;
   assign update_pc_o  = head_valid ? head.pc  : '0;
   assign update_tgt_o = head_valid ? head.tgt : '0;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected updates and redirects are queued
// at issue time and checked by an independent negedge monitor.
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_we = 1'b0;
   logic        l0_valid, l1_valid, l0_is_br, l1_is_br, l0_taken, l1_taken, l0_pred, l1_pred;
   logic [31:0] l0_pc, l1_pc, l0_tgt, l1_tgt, l0_ptgt, l1_ptgt;
   logic        wrong_pred, wasnt_branch, update_pht, update_btb, last_br, flush, drop;
   logic [31:0] fixed_pc, wasnt_br_pc, update_pc, update_tgt;

   int total = 0;
   int bad   = 0;
   logic [64:0] upd_q [$];
   logic [65:0] rd_q  [$];

   always #5 clk = ~clk;

   branch_resolver #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
      .clock_i(clk), .reset_n_i(rst_n), .pc_we_i(pc_we),
      .l0_valid_i(l0_valid), .l1_valid_i(l1_valid),
      .l0_pc_i(l0_pc), .l1_pc_i(l1_pc),
      .l0_is_br_i(l0_is_br), .l1_is_br_i(l1_is_br),
      .l0_taken_i(l0_taken), .l1_taken_i(l1_taken),
      .l0_tgt_i(l0_tgt), .l1_tgt_i(l1_tgt),
      .l0_pred_i(l0_pred), .l1_pred_i(l1_pred),
      .l0_pred_tgt_i(l0_ptgt), .l1_pred_tgt_i(l1_ptgt),
      .wrong_pred_o(wrong_pred), .fixed_pc_o(fixed_pc),
      .wasnt_branch_o(wasnt_branch), .wasnt_br_pc_o(wasnt_br_pc),
      .update_pht_o(update_pht), .update_btb_o(update_btb),
      .update_pc_o(update_pc), .update_tgt_o(update_tgt),
      .last_br_o(last_br), .flush_o(flush), .drop_o(drop)
   );

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic clr();
      {l0_valid, l1_valid, l0_is_br, l1_is_br, l0_taken, l1_taken, l0_pred, l1_pred} = '0;
      {l0_pc, l1_pc, l0_tgt, l1_tgt, l0_ptgt, l1_ptgt} = '0;
   endtask

   task automatic set_l0(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt);
      l0_valid = 1'b1; l0_pc = pc; l0_is_br = br; l0_taken = tk;
      l0_tgt = tgt; l0_pred = pr; l0_ptgt = ptgt;
   endtask

   task automatic set_l1(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt);
      l1_valid = 1'b1; l1_pc = pc; l1_is_br = br; l1_taken = tk;
      l1_tgt = tgt; l1_pred = pr; l1_ptgt = ptgt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops an update whenever fetch consumes the head, and a redirect
   // record whenever either redirect output rises.
   initial begin
      logic        prev_rd = 1'b0;
      logic [64:0] eu;
      logic [65:0] er;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rd = 1'b0;
         end else begin
            if (update_pht && pc_we) begin
               if (upd_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL upd_extra: got pc %h want no entry", update_pc);
               end else begin
                  eu = upd_q.pop_front();
                  chk("upd_entry", {1'b0, update_pc, update_tgt, update_btb}, {1'b0, eu});
                  chk("upd_last_br", 66'(last_br), 66'(eu[0]));
               end
            end
            if ((wrong_pred || wasnt_branch) && !prev_rd) begin
               if (rd_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rd_extra: got wp=%b wb=%b want no redirect", wrong_pred, wasnt_branch);
               end else begin
                  er = rd_q.pop_front();
                  chk("redirect", {wrong_pred, wasnt_branch, fixed_pc, wasnt_br_pc}, er);
               end
            end
            prev_rd = wrong_pred || wasnt_branch;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {wrong_pred, wasnt_branch, update_pht, update_btb, last_br, flush, drop}, 66'd0);
      chk("rst_pcs", {2'b0, fixed_pc, wasnt_br_pc}, 66'd0);
      rst_n = 1'b1;
      pc_we = 1'b1;

      // Correct prediction
      set_l0(32'h100, 1, 1, 32'h200, 1, 32'h200);
      upd_q.push_back({32'h100, 32'h200, 1'b1});
      step(); clr();
      chk("ok_noredir", {wrong_pred, wasnt_branch, flush}, 66'd0);
      chk("ok_head", {1'b0, update_pht, update_btb, last_br, update_pc}, {31'd0, 3'b111, 32'h100});
      step();

      // Direction mispredict, lane 1 squashed; then held redirect
      pc_we = 1'b0;
      set_l0(32'h40, 1, 0, 32'h60, 1, 32'h60);
      set_l1(32'h44, 1, 1, 32'h80, 1, 32'h80);
      upd_q.push_back({32'h40, 32'h60, 1'b0});
      rd_q.push_back({1'b1, 1'b0, 32'h44, 32'h0});
      step(); clr();
      chk("mis_out", {wrong_pred, flush, fixed_pc}, {32'd0, 2'b11, 32'h44});
      set_l0(32'h900, 1, 1, 32'h990, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(); clr();
         chk("hold", {wrong_pred, flush, fixed_pc}, {32'd0, 2'b11, 32'h44});
      end
      pc_we = 1'b1;
      step();
      chk("accept", {wrong_pred, flush, update_pht, fixed_pc}, {31'd0, 3'b010, 32'h0});
      step();
      chk("flush2", 66'(flush), 66'd1);
      step();
      chk("flush_end", 66'(flush), 66'd0);

      // False-taken on lane 1
      set_l0(32'h80, 0, 0, 32'h0, 0, 32'h0);
      set_l1(32'h84, 0, 0, 32'h0, 1, 32'h0);
      rd_q.push_back({1'b0, 1'b1, 32'h0, 32'h84});
      step(); clr();
      chk("ft_out", {wrong_pred, wasnt_branch, update_pht, wasnt_br_pc}, {31'd0, 3'b010, 32'h84});
      step();
      chk("ft_clear", {wasnt_branch, flush}, 66'b01);
      step(); step();

      // Lane 0 correct, lane 1 target mispredict: both train
      set_l0(32'h200, 1, 0, 32'h300, 0, 32'h0);
      set_l1(32'h204, 1, 1, 32'h400, 1, 32'h408);
      upd_q.push_back({32'h200, 32'h300, 1'b0});
      upd_q.push_back({32'h204, 32'h400, 1'b1});
      rd_q.push_back({1'b1, 1'b0, 32'h400, 32'h0});
      step(); clr();
      chk("l1mis_out", {wrong_pred, fixed_pc}, {33'd1, 32'h400});
      step(); step(); step();
      chk("l1mis_run", {flush, update_pht}, 66'd0);

      // Overflow with fetch stalled
      pc_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_l0(32'h300 + 32'(i * 16), 1, 0, 32'h1000, 0, 32'h0);
         upd_q.push_back({32'h300 + 32'(i * 16), 32'h1000, 1'b0});
         step(); clr();
      end
      set_l0(32'h330, 1, 1, 32'h500, 1, 32'h500);
      set_l1(32'h334, 1, 1, 32'h600, 1, 32'h600);
      upd_q.push_back({32'h330, 32'h500, 1'b1});
      step(); clr();
      chk("ovf_drop", {drop, update_pht, update_pc}, {32'd0, 2'b11, 32'h300});
      step();
      chk("ovf_drop_pulse", 66'(drop), 66'd0);
      pc_we = 1'b1;
      set_l0(32'h340, 1, 0, 32'h700, 0, 32'h0);
      set_l1(32'h344, 1, 0, 32'h700, 0, 32'h0);
      upd_q.push_back({32'h340, 32'h700, 1'b0});
      step(); clr();
      chk("full_deq_drop", 66'(drop), 66'd1);
      repeat (5) step();
      chk("drained", {drop, update_pht}, 66'd0);

      // Async reset mid-HOLD with two updates queued
      pc_we = 1'b0;
      set_l0(32'h500, 1, 0, 32'h540, 0, 32'h0);
      step(); clr();
      set_l0(32'h600, 1, 1, 32'h700, 0, 32'h0);
      rd_q.push_back({1'b1, 1'b0, 32'h700, 32'h0});
      step(); clr();
      chk("pre_rst", {wrong_pred, flush, update_pht}, 66'b111);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outs", {wrong_pred, wasnt_branch, update_pht, update_btb, last_br, flush, drop}, 66'd0);
      chk("arst_pcs", {fixed_pc, update_pc}, 66'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst", {flush, update_pht, wrong_pred}, 66'd0);
      pc_we = 1'b1;
      set_l0(32'h700, 1, 1, 32'h800, 1, 32'h800);
      upd_q.push_back({32'h700, 32'h800, 1'b1});
      step(); clr();
      chk("post_rst_run", {1'b0, flush, update_pht, update_pc}, {32'd0, 2'b01, 32'h700});
      step(); step();

      chk("upd_q_empty", 66'(upd_q.size()), 66'd0);
      chk("rd_q_empty", 66'(rd_q.size()), 66'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit for the dual-issue core. It produces the redirect and predictor-training side of the fetch1 predictor interface. Each cycle it compares the resolved outcome of up to two instructions (lane 0 older) against the prediction carried down the pipe, and raises a held redirect on misprediction or a false "taken" prediction. It queues BTB/PHT training updates in a small FIFO and drains them one per fetch write-enable.

## Interface
- `DEPTH`, default 4: update FIFO entries; must be a power of 2 and at least 2.
- `FLUSH_CYCLES`, default 2: cycles `flush_o` stays high after the redirect is accepted.
- `clock_i` in 1: core clock.
- `reset_n_i` in 1: reset, asynchronous assert, active-low.
- `pc_we_i` in 1: fetch PC write-enable. A redirect is accepted, and an update dequeued, only when this is high.
- `l0_valid_i`, `l1_valid_i` in 1: lane holds a real instruction.
- `l0_pc_i`, `l1_pc_i` in 32: instruction PC.
- `l0_is_br_i`, `l1_is_br_i` in 1: instruction is a control transfer.
- `l0_taken_i`, `l1_taken_i` in 1: resolved direction.
- `l0_tgt_i`, `l1_tgt_i` in 32: resolved target.
- `l0_pred_i`, `l1_pred_i` in 1: fetch predicted taken.
- `l0_pred_tgt_i`, `l1_pred_tgt_i` in 32: fetch predicted target.
- `wrong_pred_o` out 1: mispredict redirect, held.
- `fixed_pc_o` out 32: correct next PC.
- `wasnt_branch_o` out 1: non-branch was predicted taken, held.
- `wasnt_br_pc_o` out 32: PC of that non-branch.
- `update_pht_o` out 1: FIFO head valid.
- `update_btb_o` out 1: head entry was taken; write the BTB.
- `update_pc_o` out 32: head entry PC.
- `update_tgt_o` out 32: head entry target.
- `last_br_o` out 1: head entry direction.
- `flush_o` out 1: squash younger pipeline stages.
- `drop_o` out 1: one-cycle pulse when an update was discarded because the FIFO was full.

## Operation
- Per valid lane, in priority order:
  - Mispredict when `is_br && (taken != pred || (taken && tgt != pred_tgt))`. The fix PC is `taken ? tgt : pc+4`.
  - False-taken when `!is_br && pred`.
- Lane 0 has priority. If lane 0 mispredicts or is false-taken, lane 1 is squashed: no redirect and no update from lane 1.
- Redirect on a mispredict:
  - Register `wrong_pred_o=1` and `fixed_pc_o`.
- Redirect on a false-taken with no mispredict:
  - Register `wasnt_branch_o=1` and `wasnt_br_pc_o=pc`; fetch itself computes pc+4.
  - If both conditions come from the same winning lane, mispredict wins. This cannot happen in practice, since the two conditions are exclusive on `is_br`.
- FSM states:
  - RUN: evaluate lanes. On a redirect, move to HOLD.
  - HOLD: redirect outputs stay stable and lane inputs are ignored. On a cycle with `pc_we_i=1`, clear the redirect outputs, load the counter with `FLUSH_CYCLES`, and move to FLUSH.
  - FLUSH: lanes are ignored and the counter decrements. At 1, return to RUN. With `FLUSH_CYCLES=0`, go straight from HOLD to RUN.
- `flush_o` is high in HOLD and in FLUSH.
- Updates:
  - Every valid, non-squashed lane with `is_br` enqueues `{pc, tgt, taken}`. Lane 0 enqueues before lane 1, in the RUN state only.
  - With 0 free slots, both are dropped. With 1 free slot, lane 0 is kept and lane 1 dropped. `drop_o` pulses on any drop.
  - Free slots are counted after the same-cycle dequeue, so a full FIFO with `pc_we_i=1` accepts one entry.
  - Dequeue happens when the head is valid and `pc_we_i=1`.
- FIFO pointers wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits wide.

## Timing
- Reset state: all outputs 0, FIFO empty, state RUN, counter 0.
- Reset mid-operation: held redirects and queued updates are discarded.
- Redirect latency: 1 cycle. Lanes are sampled at edge N and `wrong_pred_o` is visible after edge N, so fetch uses it at edge N+1 if `pc_we_i` is high.
- Update outputs are combinational from the FIFO head. An entry enqueued at edge N is visible after edge N and can dequeue at edge N+1.
- `pc_we_i=0` holds everything fetch-facing stable.

## Structure
- Shared package `bp_pkg`: the update-entry struct `{pc[31:0], tgt[31:0], taken}` and the FSM state encoding RUN/HOLD/FLUSH.
- Sub-module `bp_update_fifo`: parameterised DEPTH FIFO with 2-wide enqueue, 1-wide dequeue, and a free-slot count output.
- The top level holds the lane compare logic, the FSM, the flush counter and the redirect registers.

## Test plan
- Correct prediction:
  - Stimulus: lane 0 branch, pc=0x100, taken, tgt=0x200, pred=1, pred_tgt=0x200.
  - Response: no redirect. Next cycle `update_pht_o=1`, `update_btb_o=1`, `update_pc_o=0x100`, `last_br_o=1`.
- Direction mispredict:
  - Stimulus: lane 0 pc=0x40, not taken, pred=1; lane 1 valid branch.
  - Response: `wrong_pred_o=1`, `fixed_pc_o=0x44`, only one update enqueued, `flush_o` high.
- Held redirect:
  - Stimulus: `pc_we_i=0` for 3 cycles after the redirect, then 1.
  - Response: `wrong_pred_o` holds 0x44 for those cycles, clears after the accepting edge, and `flush_o` stays high 2 more cycles.
- False-taken:
  - Stimulus: lane 1 non-branch, pc=0x84, pred=1.
  - Response: `wasnt_branch_o=1`, `wasnt_br_pc_o=0x84`, `wrong_pred_o=0`.
- Overflow:
  - Stimulus: `pc_we_i=0`; enqueue 3 branches, then a dual-branch cycle.
  - Response: FIFO count reaches 4, lane 1 dropped, `drop_o` pulses once.
- Async reset:
  - Stimulus: assert `reset_n_i` low mid-HOLD with 2 updates queued.
  - Response: all outputs 0 immediately, FIFO empty, state RUN after release.
